// File: rtl/id_stage_p.sv
// id_stage_p: instruction decode -- register file with write-through, main decoder,
//   load-use / branch-operand hazards, beq/bne resolved here, ID/EX pipeline register.
// Latency: ID/EX fields valid 1 cycle after inst; stall/redirect/IF enables are combinational.
// Backpressure: id_hold freezes ID/EX and IF; a hazard stall freezes IF and bubbles ID/EX.
// Ports: clk/rst (sync, active-high); if_valid/inst/pc_plus4 from IF/ID; id_hold freeze;
//   wb_* register-file write; mem_* EX/MEM state for branch forwarding; pc_write/if_id_write/
//   if_flush/pc_src/branch_target/jump_target back to IF; ex_* ID/EX register; stall_cnt.
module id_stage_p #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 16,
  localparam int RAW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            id_hold,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [RAW-1:0]  mem_rd,
  input  logic [XLEN-1:0] mem_alu,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            if_flush,
  output logic [1:0]      pc_src,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] jump_target,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_alusrc,
  output logic            ex_regdst,
  output logic [1:0]      ex_aluop,
  output logic [XLEN-1:0] ex_rs_data,
  output logic [XLEN-1:0] ex_rt_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [RAW-1:0]  ex_rs,
  output logic [RAW-1:0]  ex_rt,
  output logic [RAW-1:0]  ex_rd,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regdst;
    logic [1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    ctrl_t           ctl;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [RAW-1:0]  rd;
  } idex_t;

  logic [5:0]      opcode;
  logic [RAW-1:0]  rs, rt, rd;
  logic [XLEN-1:0] imm_sext;

  assign opcode   = inst[31:26];
  assign rs       = inst[21 +: RAW];
  assign rt       = inst[16 +: RAW];
  assign rd       = inst[11 +: RAW];
  assign imm_sext = {{(XLEN-16){inst[15]}}, inst[15:0]};

  // Register file
  logic [XLEN-1:0] rf [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  // Reads see a same-cycle write so WB never needs an extra cycle to reach ID.
  logic [XLEN-1:0] rs_val, rt_val, rs_cmp, rt_cmp;

  always_comb begin
    rs_val = rf[rs];
    if (wb_we && wb_rd == rs) rs_val = wb_data;
    if (rs == '0) rs_val = '0;
    rt_val = rf[rt];
    if (wb_we && wb_rd == rt) rt_val = wb_data;
    if (rt == '0) rt_val = '0;
    // Only a non-load EX/MEM result is ready early enough for the comparator.
    rs_cmp = rs_val;
    if (mem_regwrite && !mem_memread && mem_rd == rs && rs != '0) rs_cmp = mem_alu;
    rt_cmp = rt_val;
    if (mem_regwrite && !mem_memread && mem_rd == rt && rt != '0) rt_cmp = mem_alu;
  end

  // Main decoder
  ctrl_t ctl;
  logic  is_beq, is_bne, is_j, uses_rt;

  always_comb begin
    ctl     = '0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    uses_rt = 1'b0;
    if (if_valid) begin
      case (opcode)
        OP_R:    begin ctl.valid = 1'b1; ctl.regdst = 1'b1; ctl.regwrite = 1'b1;
                       ctl.aluop = 2'b10; uses_rt = 1'b1; end
        OP_LW:   begin ctl.valid = 1'b1; ctl.alusrc = 1'b1; ctl.memread = 1'b1;
                       ctl.memtoreg = 1'b1; ctl.regwrite = 1'b1; end
        OP_SW:   begin ctl.valid = 1'b1; ctl.alusrc = 1'b1; ctl.memwrite = 1'b1;
                       uses_rt = 1'b1; end
        OP_ADDI: begin ctl.valid = 1'b1; ctl.alusrc = 1'b1; ctl.regwrite = 1'b1; end
        OP_BEQ:  begin is_beq = 1'b1; uses_rt = 1'b1; end
        OP_BNE:  begin is_bne = 1'b1; uses_rt = 1'b1; end
        OP_J:    is_j = 1'b1;
        default: ;
      endcase
    end
  end

  // Hazards and redirect
  idex_t idex, id_next;
  logic  load_use, dep_rs, dep_rt, br_haz, stall, eq, taken, redirect;

  always_comb begin
    load_use = idex.ctl.valid && idex.ctl.memread && idex.rd != '0 &&
               (idex.rd == rs || (uses_rt && idex.rd == rt));
    // Branch operand still in flight: an ALU result in EX, or a load in MEM.
    dep_rs = rs != '0 && ((idex.ctl.valid && idex.ctl.regwrite && idex.rd == rs) ||
                          (mem_regwrite && mem_memread && mem_rd == rs));
    dep_rt = rt != '0 && ((idex.ctl.valid && idex.ctl.regwrite && idex.rd == rt) ||
                          (mem_regwrite && mem_memread && mem_rd == rt));
    br_haz   = (is_beq || is_bne) && (dep_rs || dep_rt);
    stall    = if_valid && (load_use || br_haz);
    eq       = rs_cmp == rt_cmp;
    taken    = (is_beq && eq) || (is_bne && !eq);
    redirect = if_valid && !stall && !id_hold;
    pc_src   = 2'b00;
    if (redirect && is_j)       pc_src = 2'b10;
    else if (redirect && taken) pc_src = 2'b01;
    if_flush = redirect && (taken || is_j);
  end

  assign pc_write      = !(stall || id_hold);
  assign if_id_write   = pc_write;
  assign branch_target = pc_plus4 + {imm_sext[XLEN-3:0], 2'b00};
  assign jump_target   = {pc_plus4[XLEN-1:28], inst[25:0], 2'b00};

  // ID/EX register; branches, jumps and unknown opcodes enter as all-zero bubbles.
  always_comb begin
    id_next = '0;
    if (ctl.valid) begin
      id_next.ctl     = ctl;
      id_next.rs_data = rs_val;
      id_next.rt_data = rt_val;
      id_next.imm     = imm_sext;
      id_next.rs      = rs;
      id_next.rt      = rt;
      id_next.rd      = ctl.regdst ? rd : rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex <= '0;
    end else if (!id_hold) begin
      idex <= stall ? '0 : id_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !id_hold && stall_cnt != {CNTW{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_valid    = idex.ctl.valid;
  assign ex_regwrite = idex.ctl.regwrite;
  assign ex_memread  = idex.ctl.memread;
  assign ex_memwrite = idex.ctl.memwrite;
  assign ex_memtoreg = idex.ctl.memtoreg;
  assign ex_alusrc   = idex.ctl.alusrc;
  assign ex_regdst   = idex.ctl.regdst;
  assign ex_aluop    = idex.ctl.aluop;
  assign ex_rs_data  = idex.rs_data;
  assign ex_rt_data  = idex.rt_data;
  assign ex_imm      = idex.imm;
  assign ex_rs       = idex.rs;
  assign ex_rt       = idex.rt;
  assign ex_rd       = idex.rd;

endmodule

// File: doc/id_stage_p.md
# id_stage_p

Parametrised instruction-decode stage for the five-stage pipeline. It contains the register file with write-through bypass, the main decoder, and load-use and branch-operand hazard detection. It resolves beq/bne in ID with EX/MEM forwarding into the comparator, and owns the ID/EX pipeline register. It sits between the IF/ID register and the EX stage and drives PC selection, stall and flush back to IF.

## Interface
Parameters:
- XLEN, 32: datapath width (≥32; immediates sign-extended to XLEN)
- NREG, 32: architectural registers (power of 2); RAW = log2(NREG) ≤ 5
- CNTW, 16: stall-counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  inst/pc_plus4 hold a real instruction
- inst  in  32  instruction from IF/ID
- pc_plus4  in  XLEN  PC+4 of inst
- id_hold  in  1  external freeze (memory stall); freezes ID/EX and IF
- wb_we, wb_rd, wb_data  in  1/RAW/XLEN  register-file write port
- mem_regwrite, mem_memread, mem_rd, mem_alu  in  1/1/RAW/XLEN  EX/MEM state for branch forwarding
- pc_write, if_id_write  out  1  IF enables; 0 while stalled
- if_flush  out  1  squash IF/ID on redirect
- pc_src  out  2  00 sequential, 01 branch target, 10 jump target
- branch_target, jump_target  out  XLEN  redirect addresses
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_alusrc, ex_regdst  out  1 each  ID/EX control
- ex_aluop  out  2  ID/EX ALU op class
- ex_rs_data, ex_rt_data, ex_imm  out  XLEN  ID/EX operands
- ex_rs, ex_rt, ex_rd  out  RAW  ID/EX register specifiers (ex_rd is already the RegDst-selected destination)
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles

## Operation
- Decoded opcodes: 0x00 R-type (regdst, regwrite, aluop 10), 0x23 lw (alusrc, memread, memtoreg, regwrite, aluop 00), 0x2B sw (alusrc, memwrite, aluop 00), 0x08 addi (alusrc, regwrite, aluop 00), 0x04 beq, 0x05 bne, 0x02 j. Any other opcode, or if_valid=0, is a bubble: ex_valid=0 and all controls 0.
- Register file: NREG×XLEN, zeroed on rst. Written at posedge when wb_we=1 and wb_rd≠0. Register 0 always reads 0. Same-cycle read of wb_rd returns wb_data (write-through).
- Register indices use the low RAW bits of the inst fields.
- uses_rt = R-type, sw, beq, bne.
- load_use = ex_valid & ex_memread & ex_rd≠0 & (ex_rd==rs | (uses_rt & ex_rd==rt)).
- br_haz (beq/bne only), for each used source s≠0: (ex_valid & ex_regwrite & ex_rd==s) or (mem_regwrite & mem_memread & mem_rd==s).
- stall = if_valid & (load_use | br_haz).
- Branch compare operand for s: mem_alu if mem_regwrite & !mem_memread & mem_rd==s & s≠0; otherwise the register-file or bypass value.
- taken = beq&eq or bne&!eq.
- branch_target = pc_plus4 + (sext(imm16)<<2), modulo 2^XLEN.
- jump_target = {pc_plus4[XLEN-1:28], inst[25:0], 2'b00}.
- Redirect when if_valid & !stall & !id_hold & (taken | j): pc_src=01 or 10, if_flush=1. Otherwise pc_src=00 and if_flush=0.
- Branches and jumps enter ID/EX as bubbles.
- stall_cnt increments on each cycle with stall=1 & id_hold=0, and saturates at 2^CNTW−1.

## Timing
- Hazard, redirect, pc_write, if_id_write, pc_src and if_flush are combinational from the current inputs and ID/EX state, valid in the same cycle.
- pc_write = if_id_write = !(stall | id_hold).
- ID/EX updates at posedge with 1-cycle latency:
  - id_hold=1: hold all ID/EX fields.
  - else stall=1: load a bubble.
  - else: load the decoded instruction.
- Load feeding a branch: 2 stall cycles (ID/EX load, then EX/MEM load). ALU result feeding a branch: 1 stall cycle, then forwarded from mem_alu.
- id_hold and stall in the same cycle: hold wins; stall_cnt does not count.
- rst: all ID/EX fields 0 (ex_valid=0), stall_cnt=0, register file 0. rst mid-stall clears the hazard next cycle.

## Test plan
- Write-through: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, and inst add $3,$5,$0 in the same cycle -> next cycle ex_rs_data=0xDEADBEEF, ex_rd=3, ex_regwrite=1.
- Load-use: lw $2 in ID/EX, then add $4,$2,$1 -> 1 cycle with pc_write=0 and bubble (ex_valid=0), then add issues. stall_cnt=1.
- Branch on ALU result: addi $1,$0,7 followed by beq $1,$2 with $2=7 -> 1 stall cycle, then mem_alu=7 forwarded, pc_src=01, if_flush=1, branch_target=pc_plus4+imm<<2.
- Branch on load: lw $1 then bne $1,$0 -> 2 stall cycles, then compare from register file after WB.
- Jump with id_hold: j 0x0100000 while id_hold=1 -> pc_src=00 and ID/EX held. Release -> pc_src=10, jump_target={pc[31:28],0x0100000,00}.
- Reset mid-operation: assert rst during a load-use stall -> next cycle all outputs 0 (ex_valid=0, stall_cnt=0) and $5 reads 0.
